// File: rtl/immediate_table_if.sv
// Decode-side bus for the immediate-constant table: read port, write port and lock control.
interface immediate_table_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_err;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             wr_err;
    logic             lock;
    logic             locked;

    modport master (
        output rd_en, rd_idx, wr_en, wr_idx, wr_data, lock,
        input  rd_data, rd_valid, rd_err, wr_err, locked
    );

    modport slave (
        input  rd_en, rd_idx, wr_en, wr_idx, wr_data, lock,
        output rd_data, rd_valid, rd_err, wr_err, locked
    );
endinterface

// File: rtl/immediate_table.sv
// Writable immediate-constant table feeding the ALU B-operand mux.
// One-cycle registered read, write-first bypass, sticky write lock.
module immediate_table #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    immediate_table_if.slave   bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

    // ISA default constant set; entries past the list reset to zero.
    function automatic logic [WIDTH-1:0] rst_val(input int unsigned i);
        case (i)
            0:       return WIDTH'(32'd0);
            1:       return WIDTH'(32'd1);
            2:       return WIDTH'(32'd29);
            3:       return WIDTH'(32'd128);
            4:       return WIDTH'(32'd59);
            5:       return WIDTH'(32'd4);
            6:       return WIDTH'(32'd2);
            default: return '0;
        endcase
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic             wr_err_q, wr_err_d;
    logic             locked_q, locked_d;

    logic             rd_in_range_c;
    logic             wr_ok_c;
    logic [WIDTH-1:0] rd_mem_c;

    always_comb begin
        rd_in_range_c = ({1'b0, bus.rd_idx} < DEPTH_L);
        wr_ok_c       = bus.wr_en && !locked_q && ({1'b0, bus.wr_idx} < DEPTH_L);

        rd_mem_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bus.rd_idx == IDX_W'(i)) rd_mem_c = mem_q[i];
        end

        rd_data_d  = rd_data_q;
        rd_valid_d = bus.rd_en;
        rd_err_d   = 1'b0;
        if (bus.rd_en) begin
            if (!rd_in_range_c) begin
                rd_data_d = '0;
                rd_err_d  = 1'b1;
            end else if (wr_ok_c && (bus.wr_idx == bus.rd_idx)) begin
                rd_data_d = bus.wr_data;
            end else begin
                rd_data_d = rd_mem_c;
            end
        end

        wr_err_d = bus.wr_en && !wr_ok_c;
        locked_d = locked_q | bus.lock;
    end

    // Table storage: reset to defaults, updated only by accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= rst_val(i);
        end else if (wr_ok_c) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (bus.wr_idx == IDX_W'(i)) mem_q[i] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.wr_err   = wr_err_q;
    assign bus.locked   = locked_q;
endmodule

// File: tb/tb_immediate_table.sv
// Scoreboard bench for immediate_table at WIDTH=8, DEPTH=12.
module tb_immediate_table;
    localparam int unsigned W = 8;
    localparam int unsigned D = 12;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    exp_t         sb[$];
    logic [W-1:0] model_mem [D];
    logic         model_locked;
    logic         exp_wr_err;
    logic         exp_valid;
    logic [W-1:0] last_data;

    immediate_table_if #(.WIDTH(W), .DEPTH(D)) bus ();

    immediate_table #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        model_mem    = '{8'd0, 8'd1, 8'd29, 8'd128, 8'd59, 8'd4, 8'd2,
                         8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        model_locked = 1'b0;
        exp_wr_err   = 1'b0;
        exp_valid    = 1'b0;
        last_data    = '0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, push the expected read result, sample #1 after the edge.
    task automatic drive(input logic re, input logic [3:0] ri, input logic we,
                         input logic [3:0] wi, input logic [7:0] wd, input logic lk);
        exp_t e;
        logic wr_ok;
        @(negedge clk);
        bus.rd_en = re; bus.rd_idx = ri;
        bus.wr_en = we; bus.wr_idx = wi; bus.wr_data = wd;
        bus.lock  = lk;
        wr_ok      = we && !model_locked && (ri < 4'd12 || 1'b1) && (wi < 4'd12);
        exp_wr_err = we && !wr_ok;
        exp_valid  = re;
        if (re) begin
            if (ri >= 4'd12)               e = '{8'h00, 1'b1};
            else if (wr_ok && (wi == ri))  e = '{wd, 1'b0};
            else                           e = '{model_mem[ri], 1'b0};
            sb.push_back(e);
            last_data = e.data;
        end
        if (wr_ok) model_mem[wi] = wd;
        if (lk) model_locked = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rd_en = 0; bus.rd_idx = '0; bus.wr_en = 0; bus.wr_idx = '0;
        bus.wr_data = '0; bus.lock = 0;
        #3;
        total++; if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); else passed++;
        total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); else passed++;
        total++; if (bus.rd_err !== 1'b0) $display("FAIL reset_rd_err got=%b exp=0", bus.rd_err); else passed++;
        total++; if (bus.wr_err !== 1'b0) $display("FAIL reset_wr_err got=%b exp=0", bus.wr_err); else passed++;
        total++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", bus.locked); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Reads every entry back to back; also the idle cycle after must hold rd_data.
    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < int'(D); i++) begin
            drive(1'b1, 4'(i), 1'b0, 4'd0, 8'd0, 1'b0);
            total++;
            if (bus.rd_valid !== 1'b1) $display("FAIL b2b_valid idx=%0d got=%b exp=1", i, bus.rd_valid);
            else passed++;
            if (bus.rd_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (bus.rd_data !== e.data || bus.rd_err !== e.err)
                    $display("FAIL b2b_data idx=%0d got=%h/%b exp=%h/%b", i, bus.rd_data, bus.rd_err, e.data, e.err);
                else passed++;
            end
        end
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0);
        total++;
        if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0 || bus.rd_data !== last_data)
            $display("FAIL idle_hold got=%b/%b/%h exp=0/0/%h", bus.rd_valid, bus.rd_err, bus.rd_data, last_data);
        else passed++;
    endtask

    task automatic test_write();
        exp_t e;
        drive(1'b0, 4'd0, 1'b1, 4'd3, 8'hAA, 1'b0);
        total++; if (bus.wr_err !== 1'b0) $display("FAIL wr_accept_err got=%b exp=0", bus.wr_err); else passed++;
        for (int i = 3; i <= 4; i++) begin
            drive(1'b1, 4'(i), 1'b0, 4'd0, 8'd0, 1'b0);
            total++;
            if (bus.rd_valid !== 1'b1 || sb.size() == 0) $display("FAIL wr_rd_valid idx=%0d got=%b exp=1", i, bus.rd_valid);
            else begin
                e = sb.pop_front();
                if (bus.rd_data !== e.data || bus.rd_err !== e.err)
                    $display("FAIL wr_rd_data idx=%0d got=%h exp=%h", i, bus.rd_data, e.data);
                else passed++;
            end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        drive(1'b1, 4'd5, 1'b1, 4'd5, 8'h55, 1'b0);
        total++; if (bus.wr_err !== 1'b0) $display("FAIL coll_wr_err got=%b exp=0", bus.wr_err); else passed++;
        total++;
        if (bus.rd_valid !== 1'b1 || sb.size() == 0) $display("FAIL coll_valid got=%b exp=1", bus.rd_valid);
        else begin
            e = sb.pop_front();
            if (bus.rd_data !== e.data || e.data !== 8'h55) $display("FAIL coll_data got=%h exp=55", bus.rd_data);
            else passed++;
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        drive(1'b1, 4'd13, 1'b0, 4'd0, 8'd0, 1'b0);
        total++;
        if (bus.rd_valid !== 1'b1 || sb.size() == 0) $display("FAIL oor_valid got=%b exp=1", bus.rd_valid);
        else begin
            e = sb.pop_front();
            if (bus.rd_data !== e.data || bus.rd_err !== e.err)
                $display("FAIL oor_rd got=%h/%b exp=%h/%b", bus.rd_data, bus.rd_err, e.data, e.err);
            else passed++;
        end
        drive(1'b0, 4'd0, 1'b1, 4'd14, 8'hEE, 1'b0);
        total++; if (bus.wr_err !== exp_wr_err) $display("FAIL oor_wr_err got=%b exp=%b", bus.wr_err, exp_wr_err); else passed++;
        drive(1'b0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0);
        total++; if (bus.wr_err !== 1'b0) $display("FAIL oor_wr_err_pulse got=%b exp=0", bus.wr_err); else passed++;
        for (int i = 0; i < int'(D); i++) begin
            drive(1'b1, 4'(i), 1'b0, 4'd0, 8'd0, 1'b0);
            if (bus.rd_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (bus.rd_data !== e.data) $display("FAIL oor_nochange idx=%0d got=%h exp=%h", i, bus.rd_data, e.data);
                else passed++;
            end else begin
                total++;
                $display("FAIL oor_nochange_valid idx=%0d got=%b exp=1", i, bus.rd_valid);
            end
        end
    endtask

    task automatic test_lock();
        exp_t e;
        drive(1'b0, 4'd0, 1'b1, 4'd6, 8'h77, 1'b1);
        total++; if (bus.wr_err !== 1'b0) $display("FAIL lock_same_cycle_wr got=%b exp=0", bus.wr_err); else passed++;
        total++; if (bus.locked !== 1'b1) $display("FAIL lock_set got=%b exp=1", bus.locked); else passed++;
        drive(1'b1, 4'd2, 1'b1, 4'd2, 8'h11, 1'b0);
        total++; if (bus.wr_err !== exp_wr_err || exp_wr_err !== 1'b1) $display("FAIL lock_wr_err got=%b exp=1", bus.wr_err); else passed++;
        total++;
        if (bus.rd_valid !== 1'b1 || sb.size() == 0) $display("FAIL lock_nobypass_valid got=%b exp=1", bus.rd_valid);
        else begin
            e = sb.pop_front();
            if (bus.rd_data !== e.data || bus.rd_data !== 8'd29) $display("FAIL lock_nobypass got=%h exp=1d", bus.rd_data);
            else passed++;
        end
        for (int i = 2; i <= 6; i += 4) begin
            drive(1'b1, 4'(i), 1'b0, 4'd0, 8'd0, 1'b0);
            total++;
            if (i == 2 && bus.wr_err !== 1'b0) $display("FAIL lock_wr_err_pulse got=%b exp=0", bus.wr_err);
            else if (bus.rd_valid !== 1'b1 || sb.size() == 0) $display("FAIL lock_rd_valid idx=%0d got=%b exp=1", i, bus.rd_valid);
            else begin
                e = sb.pop_front();
                if (bus.rd_data !== e.data || bus.locked !== 1'b1)
                    $display("FAIL lock_rd idx=%0d got=%h/%b exp=%h/1", i, bus.rd_data, bus.locked, e.data);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        exp_t e;
        test_reset();
        drive(1'b0, 4'd0, 1'b1, 4'd3, 8'hAA, 1'b1);
        total++; if (bus.locked !== 1'b1 || bus.wr_err !== 1'b0) $display("FAIL mid_setup got=%b/%b exp=1/0", bus.locked, bus.wr_err); else passed++;
        @(negedge clk);
        bus.rd_en = 1'b1; bus.rd_idx = 4'd3; bus.wr_en = 1'b0; bus.lock = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.rd_valid !== 1'b0 || bus.locked !== 1'b0 || bus.rd_data !== 8'h00)
            $display("FAIL mid_reset got=%b/%b/%h exp=0/0/00", bus.rd_valid, bus.locked, bus.rd_data);
        else passed++;
        @(negedge clk);
        bus.rd_en = 1'b0;
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 4'd3, 1'b0, 4'd0, 8'd0, 1'b0);
        total++;
        if (bus.rd_valid !== 1'b1 || sb.size() == 0) $display("FAIL mid_reread_valid got=%b exp=1", bus.rd_valid);
        else begin
            e = sb.pop_front();
            if (bus.rd_data !== e.data || bus.rd_data !== 8'd128) $display("FAIL mid_reread got=%h exp=80", bus.rd_data);
            else passed++;
        end
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        bus.rd_en = 0; bus.rd_idx = '0; bus.wr_en = 0; bus.wr_idx = '0;
        bus.wr_data = '0; bus.lock = 0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_write();
        test_collision();
        test_out_of_range();
        test_lock();
        test_reset_mid_read();
        total++;
        if (sb.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
